slice_packer: RTL and testbench
===============================

SLICE_PACKER -- requirements
Module: slice_packer

Interface
REQ-001 Parameter: FILL, default 2'b11, value placed in any slot not written before a word completes.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream slice present.
REQ-005 Port: in_ready  output  1  block accepts slice this cycle.
REQ-006 Port: in_data  input  2  slice payload.
REQ-007 Port: in_sel  input  2  target slot; 00->word[1:0], 01->[3:2], 10->[5:4], 11->[7:6].
REQ-008 Port: in_last  input  1  force word completion with this beat.
REQ-009 Port: out_valid  output  1  packed word present.
REQ-010 Port: out_ready  input  1  downstream accepts word.
REQ-011 Port: out_data  output  8  packed word.
REQ-012 Port: out_mask  output  4  slots written in out_data (bit n = slot n).
REQ-013 Port: err  output  1  sticky duplicate-slot flag.
REQ-014 Port: word_cnt  output  8  count of words delivered (out_valid && out_ready).

Function
REQ-015 Beat accepted iff in_valid && in_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready (combinational; no other dependency).
REQ-017 Accepted beat SHALL write in_data into accumulator slot in_sel and set mask bit in_sel.
REQ-018 Beat completes the word if, after its write, mask == 4'b1111 or in_last == 1.
REQ-019 On completing beat in cycle N: out_data/out_mask load in cycle N+1 with out_valid = 1; unwritten slots carry FILL; accumulator and mask clear to 0 the same edge.
REQ-020 Latency: completing beat to out_valid SHALL be exactly 1 cycle.
REQ-021 out_data, out_mask SHALL hold stable while out_valid && !out_ready.
REQ-022 out_valid clears after out_valid && out_ready unless a completing beat is accepted in the same cycle, in which case out_valid stays 1 and new word loads (back-to-back, no bubble).
REQ-023 Non-completing beats accepted while output pending only if out_ready (per REQ-016); accumulator never overwrites the output register.
REQ-024 Duplicate write (mask bit in_sel already set in current word): slot overwritten with new in_data, err set to 1, held until rst.
REQ-025 in_last with mask empty and single beat: word holds that slot, other three FILL, out_mask one-hot.
REQ-026 word_cnt increments by 1 on each out_valid && out_ready, wraps 8'hFF -> 8'h00.
REQ-027 States: EMPTY (mask 0, !out_valid), FILL (mask != 0, !out_valid), PEND (out_valid, mask 0), PEND_FILL (out_valid, mask != 0); transitions solely per REQ-017..REQ-022.
REQ-028 Beats with in_valid low SHALL NOT alter any state regardless of in_sel/in_data/in_last.

Reset
REQ-029 While rst = 1 at a rising edge: out_valid = 0, out_data = 8'h00, out_mask = 4'h0, err = 0, word_cnt = 8'h00, accumulator and mask = 0; no beat accepted that cycle.
REQ-030 rst mid-word or with word pending SHALL discard partial and pending data; no word delivered from pre-reset beats.
REQ-031 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-032 Slices sel 0,1,2,3 data 01,10,11,00, out_ready=1 -> out_data 8'h39, out_mask 4'hF, out_valid one cycle after 4th beat, word_cnt 1.
REQ-033 Single beat sel 10 data 00 with in_last -> out_data 8'hCF, out_mask 4'b0100.
REQ-034 out_ready held 0 with word pending -> in_ready 0, out_data stable 5 cycles; raise out_ready with completing beat same cycle -> new word next cycle, no bubble.
REQ-035 Beats sel 1 data 01, sel 1 data 10, then in_last sel 0 data 11 -> err 1 sticky, out_data 8'hFB, out_mask 4'b0011.
REQ-036 rst asserted after 2 of 4 slices, then 4 fresh slices -> exactly one word, containing only post-reset data; word_cnt 1.
REQ-037 256 delivered words -> word_cnt wraps to 8'h00.

Source files
------------

// File: rtl/slice_packer.sv
// slice_packer: accumulates 2-bit slices into 8-bit words, padding unwritten slots with FILL.
// A completed word moves to a one-deep output register while the next word accumulates.
module slice_packer #(
    parameter logic [1:0] FILL = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_data,
    input  logic [1:0] in_sel,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [3:0] out_mask,
    output logic       err,
    output logic [7:0] word_cnt
);
    // bit 1 = output pending, bit 0 = partial word present
    typedef enum logic [1:0] {S_EMPTY, S_FILL, S_PEND, S_PEND_FILL} state_t;

    state_t     r_state, w_state_n;
    logic [7:0] r_acc, w_acc_n, w_word;
    logic [3:0] r_mask, w_mask_n, w_mask_nxt;
    logic [7:0] r_data, r_cnt;
    logic [3:0] r_omask;
    logic       r_err, w_take, w_done, w_ov_n;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_EMPTY;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_take     = in_valid && in_ready;
        w_acc_n    = r_acc;
        w_acc_n[{in_sel, 1'b0} +: 2] = in_data;
        w_mask_n   = r_mask | (4'b0001 << in_sel);
        w_done     = w_take && (w_mask_n == 4'b1111 || in_last);
        w_ov_n     = w_done || (out_valid && !out_ready);
        w_mask_nxt = w_done ? 4'b0000 : w_take ? w_mask_n : r_mask;
        w_state_n  = state_t'({w_ov_n, |w_mask_nxt});
        for (int n = 0; n < 4; n++)
            w_word[2*n +: 2] = w_mask_n[n] ? w_acc_n[2*n +: 2] : FILL;
    end

    always_comb begin
        out_valid = r_state == S_PEND || r_state == S_PEND_FILL;
        in_ready  = !out_valid || out_ready;
        out_data  = r_data;
        out_mask  = r_omask;
        err       = r_err;
        word_cnt  = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_mask  <= '0;
            r_data  <= '0;
            r_omask <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_mask <= w_mask_nxt;
            r_acc  <= w_done ? 8'h00 : w_take ? w_acc_n : r_acc;
            if (w_done) begin
                r_data  <= w_word;
                r_omask <= w_mask_n;
            end
            if (w_take && r_mask[in_sel]) r_err <= 1'b1;
            if (out_valid && out_ready) r_cnt <= r_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_slice_packer.sv
// tb_slice_packer: directed and random beats checked against a slot-level reference model.
module tb_slice_packer;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_last, out_ready;
    logic [1:0] in_data, in_sel;
    logic       in_ready, out_valid, err;
    logic [7:0] out_data, word_cnt;
    logic [3:0] out_mask;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0] m_slot [4];
    bit         m_wr   [4];
    bit         m_ov, m_err;
    logic [7:0] m_data, m_cnt;
    logic [3:0] m_mask;

    slice_packer #(.FILL(2'b11)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge, from the packing rules.
    task automatic model_edge();
        bit take, deliver, all_wr;
        int w;
        if (rst) begin
            m_ov = 0; m_err = 0; m_data = 0; m_mask = 0; m_cnt = 0;
            for (int i = 0; i < 4; i++) begin m_wr[i] = 0; m_slot[i] = 0; end
            return;
        end
        take    = in_valid && (!m_ov || out_ready);
        deliver = m_ov && out_ready;
        if (deliver) m_cnt = m_cnt + 8'd1;
        if (deliver) m_ov = 0;
        if (take) begin
            if (m_wr[in_sel]) m_err = 1;
            m_slot[in_sel] = in_data;
            m_wr[in_sel]   = 1;
            all_wr = m_wr[0] && m_wr[1] && m_wr[2] && m_wr[3];
            if (all_wr || in_last) begin
                w = 0;
                for (int i = 0; i < 4; i++) begin
                    w += (m_wr[i] ? int'(m_slot[i]) : 3) * (4 ** i);
                    m_mask[i] = m_wr[i];
                    m_wr[i] = 0;
                    m_slot[i] = 0;
                end
                m_data = w[7:0];
                m_ov = 1;
            end
        end
    endtask

    task automatic step(input bit v, input logic [1:0] sel, input logic [1:0] d,
                        input bit last, input bit ordy);
        in_valid = v; in_sel = sel; in_data = d; in_last = last; out_ready = ordy;
        #1;
        if (!rst) chk("in_ready", {7'b0, in_ready}, {7'b0, !m_ov || ordy});
        @(posedge clk);
        model_edge();
        #1;
        chk("out_valid", {7'b0, out_valid}, {7'b0, m_ov});
        chk("out_data", out_data, m_data);
        chk("out_mask", {4'b0, out_mask}, {4'b0, m_mask});
        chk("err", {7'b0, err}, {7'b0, m_err});
        chk("word_cnt", word_cnt, m_cnt);
    endtask

    task automatic do_reset();
        rst = 1;
        step(1, 2'd3, 2'd1, 1, 1);
        rst = 0;
    endtask

    initial begin
        rst = 0;
        for (int i = 0; i < 4; i++) begin m_wr[i] = 0; m_slot[i] = 0; end
        m_ov = 0; m_err = 0; m_data = 0; m_mask = 0; m_cnt = 0;
        do_reset();
        chk("reset_valid", {7'b0, out_valid}, 8'h00);
        chk("reset_data", out_data, 8'h00);

        // four slices filling a word
        step(1, 2'd0, 2'b01, 0, 1);
        step(1, 2'd1, 2'b10, 0, 1);
        step(1, 2'd2, 2'b11, 0, 1);
        step(1, 2'd3, 2'b00, 0, 1);
        chk("full_word", out_data, 8'h39);
        chk("full_mask", {4'b0, out_mask}, 8'h0F);
        step(0, 2'd0, 2'd0, 0, 1);
        chk("full_cnt", word_cnt, 8'h01);

        // single beat with in_last
        step(1, 2'd2, 2'b00, 1, 0);
        chk("last_word", out_data, 8'hCF);
        chk("last_mask", {4'b0, out_mask}, 8'h04);

        // output stalled for five cycles, then completing beat as it drains
        for (int i = 0; i < 5; i++) begin
            step(1, 2'(i), 2'(i), 0, 0);
            chk("stall_ready", {7'b0, in_ready}, 8'h00);
            chk("stall_data", out_data, 8'hCF);
        end
        step(1, 2'd1, 2'b00, 1, 1);
        chk("b2b_valid", {7'b0, out_valid}, 8'h01);
        chk("b2b_data", out_data, 8'hF3);
        step(0, 2'd0, 2'd0, 0, 1);

        // duplicate slot write
        step(1, 2'd1, 2'b01, 0, 1);
        step(1, 2'd1, 2'b10, 0, 1);
        step(1, 2'd0, 2'b11, 1, 1);
        chk("dup_word", out_data, 8'hFB);
        chk("dup_mask", {4'b0, out_mask}, 8'h03);
        step(0, 2'd0, 2'd0, 0, 1);
        chk("dup_err", {7'b0, err}, 8'h01);

        // reset mid-word discards the partial data
        step(1, 2'd0, 2'b00, 0, 1);
        step(1, 2'd1, 2'b00, 0, 1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 2'(i), 2'(3 - i), 0, 1);
        chk("post_rst_word", out_data, 8'h1B);
        step(0, 2'd0, 2'd0, 0, 1);
        chk("post_rst_cnt", word_cnt, 8'h01);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 3) != 0, 2'($urandom), 2'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
        rst = 0;

        // 256 deliveries wrap word_cnt
        do_reset();
        for (int i = 0; i < 256; i++) step(1, 2'($urandom), 2'($urandom), 1, 1);
        step(0, 2'd0, 2'd0, 0, 1);
        chk("cnt_wrap", word_cnt, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
